alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
- Sequencer and controller for the 8-bit adder datapath and its operand-select stage.
- Operand-select encoding on S:
  - S=00: OPB=B, carry-in 0 (ADD).
  - S=01: OPB=~B, carry-in 1 (SUB).
  - S=10: OPB=0, carry-in 1 (INC).
  - S=11: OPB=0, carry-in 0 (PASS).
- Accepts one command at a time over a valid/ready handshake.
- Single-pass ops take one pass through the adder. MUL is iterated as shift-add over WIDTH cycles.
- Returns a registered result and flags over a valid/ready output handshake.

Parameters:
WIDTH, 8, operand width; adder width is WIDTH, product width is 2*WIDTH

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
IN_VALID  input  1  command valid
IN_READY  output  1  block can accept command
OP  input  3  000 ADD, 001 SUB, 010 INC, 011 PASS, 100 MUL, others illegal
A  input  WIDTH  first operand
B  input  WIDTH  second operand
OUT_VALID  output  1  result valid
OUT_READY  input  1  consumer accepts result
RES  output  2*WIDTH  result; upper WIDTH bits are zero for non-MUL ops
C  output  1  adder carry-out (SUB: 1 = no borrow); 0 for MUL/illegal
Z  output  1  RES == 0
ERR  output  1  illegal opcode

Behaviour:
- Reset (async, any state, including mid-MUL):
  - State goes to IDLE.
  - RES=0, C=0, Z=0, ERR=0, OUT_VALID=0. IN_READY=1 once in IDLE.
  - All internal registers (multiplicand, product, counter) clear. An aborted command produces no output.
- States: IDLE, EXEC, MUL, DONE.
- IN_READY = (state == IDLE). It is combinational from state only and never depends on IN_VALID.
- Accept:
  - A command is accepted on a rising edge with IN_VALID & IN_READY.
  - On accept, OP, A and B are captured into registers. Inputs are don't-care afterwards.
  - Non-MUL opcodes go to EXEC. OP=100 goes to MUL.
- EXEC (1 cycle):
  - Adder computes sum = A + OPB + cin, using the S encoding above with S[1:0]=OP[1:0].
  - Legal op:
    - RES = {0, sum[WIDTH-1:0]}.
    - C = sum carry-out, with cin folded in.
    - ERR = 0.
  - Illegal op (101, 110, 111): RES=0, C=0, ERR=1.
  - Next state is DONE.
  - Result: OUT_VALID rises at the edge 2 after accept.
- MUL (shift-add, reusing the adder with S=00):
  - Product register P[2*WIDTH-1:0] is initialised to {0, B} at accept. Counter is 0.
  - Each cycle:
    - If P[0]=1: {cout, hi} = P[2W-1:W] + A.
    - Else: cout=0 and hi unchanged.
    - Then P = {cout, hi, P[W-1:1]} (logical right shift through cout).
    - Counter increments.
  - After exactly WIDTH iterations: RES = P, C=0, ERR=0, next state DONE.
  - Result: OUT_VALID rises at edge WIDTH+1 after accept, i.e. edge 9 for WIDTH=8.
- Z is registered together with RES and always equals (RES == 0), ERR cases included.
- DONE:
  - OUT_VALID=1. RES, C, Z, ERR are held stable while OUT_READY=0.
  - On an edge with OUT_READY=1: OUT_VALID goes to 0 and state goes to IDLE.
  - RES, C, Z, ERR keep their last values until the next result is registered.
- No accept is possible in the same edge as output retire. Minimum command-to-command spacing is therefore 3 cycles for single-pass ops.
- IN_VALID high outside IDLE is ignored; the command is not queued.
- Widths:
  - All adder arithmetic is modulo 2^WIDTH, with carry-out kept.
  - PASS yields RES=A, C=0.
  - INC of all-ones yields 0, C=1.

Optional Feature:
ALU_SEQ_SAT_EN
- Defined: ADD and INC saturate to all-ones when carry-out=1, and SUB clamps to 0 when carry-out=0 (borrow). C still reports the raw carry-out, and Z reflects the saturated RES. MUL, PASS and illegal ops are unaffected.
- Undefined: wrap-around results exactly as described in Behaviour.

Test Plan:
- ADD A=0xF0 B=0x20, OUT_READY=1 -> RES=0x0010, C=1, Z=0, ERR=0; OUT_VALID high exactly 2 edges after accept. With ALU_SEQ_SAT_EN: RES=0x00FF.
- SUB A=0x05 B=0x05 -> RES=0, C=1, Z=1. SUB A=0x03 B=0x05 -> RES=0x00FE, C=0 (SAT_EN: RES=0, Z=1).
- INC A=0xFF -> RES=0, C=1, Z=1. PASS A=0x5A B=0x33 -> RES=0x005A, C=0.
- MUL A=0xFF B=0xFF -> RES=0xFE01, OUT_VALID at edge 9 after accept. MUL A=0x00 B=0x7F -> RES=0, Z=1.
- Backpressure: ADD 0x01+0x01 with OUT_READY=0 for 5 cycles -> OUT_VALID, RES=0x0002 held and IN_READY=0 throughout; new IN_VALID ignored. Retire on the OUT_READY edge, IN_READY=1 the next cycle.
- Illegal OP=111 -> ERR=1, RES=0, Z=1. rst pulsed at MUL iteration 4 -> immediately OUT_VALID=0, IN_READY=1, RES=0. A following ADD 0x02+0x03 yields 0x0005.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// Sequencer/controller for an 8-bit adder datapath: single-pass ADD/SUB/INC/PASS
// and iterative shift-add MUL. Optional macro ALU_SEQ_SAT_EN enables saturating ADD/INC/SUB.
module alu_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [2:0]           OP,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [2*WIDTH-1:0]   RES,
    output logic                 C,
    output logic                 Z,
    output logic                 ERR
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_INC = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b100;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

    state_t               state_q, state_d;
    logic [2:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   res_q, res_d;
    logic                 c_q, c_d, z_q, z_d, err_q, err_d;

    logic [WIDTH-1:0]     add_a, add_b;
    logic                 cin;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     alu_res;

`ifdef ALU_SEQ_SAT_EN
    // Clamp on overflow (ADD/INC) or borrow (SUB); other ops pass the raw sum.
    function automatic logic [WIDTH-1:0] sat_res(input logic [2:0] op, input logic [WIDTH:0] s);
        case (op)
            OP_ADD, OP_INC: return s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
            OP_SUB:         return s[WIDTH] ? s[WIDTH-1:0] : {WIDTH{1'b0}};
            default:        return s[WIDTH-1:0];
        endcase
    endfunction
    assign alu_res = sat_res(op_q, sum);
`else
    assign alu_res = sum[WIDTH-1:0];
`endif

    // Shared adder: operand select from OP[1:0] in EXEC, accumulate-high in MUL.
    always_comb begin
        add_a = a_q;
        add_b = b_q;
        cin   = 1'b0;
        if (state_q == MUL) begin
            add_a = p_q[2*WIDTH-1:WIDTH];
            add_b = p_q[0] ? a_q : {WIDTH{1'b0}};
        end else begin
            case (op_q[1:0])
                2'b00: begin add_b = b_q;            cin = 1'b0; end
                2'b01: begin add_b = ~b_q;           cin = 1'b1; end
                2'b10: begin add_b = {WIDTH{1'b0}};  cin = 1'b1; end
                default: begin add_b = {WIDTH{1'b0}}; cin = 1'b0; end
            endcase
        end
    end

    assign sum = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, cin};

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        c_d     = c_q;
        z_d     = z_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (IN_VALID) begin
                    op_d    = OP;
                    a_d     = A;
                    b_d     = B;
                    p_d     = {{WIDTH{1'b0}}, B};
                    cnt_d   = '0;
                    state_d = (OP == OP_MUL) ? MUL : EXEC;
                end
            end
            EXEC: begin
                if (op_q[2]) begin
                    res_d = '0;
                    c_d   = 1'b0;
                    err_d = 1'b1;
                end else begin
                    res_d = {{WIDTH{1'b0}}, alu_res};
                    c_d   = sum[WIDTH];
                    err_d = 1'b0;
                end
                z_d     = (res_d == '0);
                state_d = DONE;
            end
            MUL: begin
                p_d   = {sum, p_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    res_d   = p_d;
                    c_d     = 1'b0;
                    err_d   = 1'b0;
                    z_d     = (p_d == '0);
                    state_d = DONE;
                end
            end
            default: begin
                if (OUT_READY) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            c_q     <= c_d;
            z_q     <= z_d;
            err_q   <= err_d;
        end
    end

    assign IN_READY  = (state_q == IDLE);
    assign OUT_VALID = (state_q == DONE);
    assign RES       = res_q;
    assign C         = c_q;
    assign Z         = z_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed self-checking bench for alu_seq_ctrl (WIDTH=8), expected values hand-computed.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  op;
    logic [7:0]  a, b;
    logic [15:0] res;
    logic        c, z, err;

    int n_cmp = 0;
    int n_bad = 0;
    int lat;

`ifdef ALU_SEQ_SAT_EN
    localparam logic [15:0] E_ADD  = 16'h00FF;
    localparam logic [15:0] E_SUB2 = 16'h0000;
    localparam logic        E_SUB2_Z = 1'b1;
    localparam logic [15:0] E_INC  = 16'h00FF;
    localparam logic        E_INC_Z = 1'b0;
`else
    localparam logic [15:0] E_ADD  = 16'h0010;
    localparam logic [15:0] E_SUB2 = 16'h00FE;
    localparam logic        E_SUB2_Z = 1'b0;
    localparam logic [15:0] E_INC  = 16'h0000;
    localparam logic        E_INC_Z = 1'b1;
`endif

    alu_seq_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .IN_VALID(in_valid), .IN_READY(in_ready),
        .OP(op), .A(a), .B(b),
        .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .RES(res), .C(c), .Z(z), .ERR(err)
    );

    always #5 clk = ~clk;

    // Issue one command; lat counts edges from accept (accept edge = 1) until OUT_VALID.
    task automatic run_cmd(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv, output int l);
        in_valid = 1'b1; op = o; a = av; b = bv;
        @(posedge clk); #1;
        in_valid = 1'b0; op = 3'b000; a = 8'h00; b = 8'h00;
        l = 1;
        while (out_valid !== 1'b1 && l < 40) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({out_valid, in_ready, res, c, z, err} !== {1'b0, 1'b1, 16'h0000, 3'b000}) begin
            n_bad++;
            $display("FAIL reset: got ov=%b ir=%b res=%h c=%b z=%b err=%b want ov=0 ir=1 res=0000 c=0 z=0 err=0",
                     out_valid, in_ready, res, c, z, err);
        end
    endtask

    task automatic test_add();
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL add_ready: got %b want 1", in_ready); end
        run_cmd(3'b000, 8'hF0, 8'h20, lat);
        n_cmp++;
        if (lat !== 2) begin n_bad++; $display("FAIL add_latency: got %0d want 2", lat); end
        n_cmp++;
        if ({res, c, z, err} !== {E_ADD, 1'b1, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL add_result: got res=%h c=%b z=%b err=%b want res=%h c=1 z=0 err=0", res, c, z, err, E_ADD);
        end
        retire();
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_bad++; $display("FAIL add_retire: got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
        end
    endtask

    task automatic test_sub();
        run_cmd(3'b001, 8'h05, 8'h05, lat);
        n_cmp++;
        if ({res, c, z, err} !== {16'h0000, 1'b1, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL sub_equal: got res=%h c=%b z=%b err=%b want res=0000 c=1 z=1 err=0", res, c, z, err);
        end
        retire();
        run_cmd(3'b001, 8'h03, 8'h05, lat);
        n_cmp++;
        if ({res, c, z, err} !== {E_SUB2, 1'b0, E_SUB2_Z, 1'b0}) begin
            n_bad++; $display("FAIL sub_borrow: got res=%h c=%b z=%b err=%b want res=%h c=0 z=%b err=0",
                              res, c, z, err, E_SUB2, E_SUB2_Z);
        end
        retire();
    endtask

    task automatic test_inc_pass();
        run_cmd(3'b010, 8'hFF, 8'h12, lat);
        n_cmp++;
        if ({res, c, z, err} !== {E_INC, 1'b1, E_INC_Z, 1'b0}) begin
            n_bad++; $display("FAIL inc_wrap: got res=%h c=%b z=%b err=%b want res=%h c=1 z=%b err=0",
                              res, c, z, err, E_INC, E_INC_Z);
        end
        retire();
        run_cmd(3'b011, 8'h5A, 8'h33, lat);
        n_cmp++;
        if ({res, c, z, err} !== {16'h005A, 1'b0, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL pass: got res=%h c=%b z=%b err=%b want res=005a c=0 z=0 err=0", res, c, z, err);
        end
        retire();
    endtask

    task automatic test_mul();
        run_cmd(3'b100, 8'hFF, 8'hFF, lat);
        n_cmp++;
        if (lat !== 9) begin n_bad++; $display("FAIL mul_latency: got %0d want 9", lat); end
        n_cmp++;
        if ({res, c, z, err} !== {16'hFE01, 1'b0, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL mul_ff: got res=%h c=%b z=%b err=%b want res=fe01 c=0 z=0 err=0", res, c, z, err);
        end
        retire();
        run_cmd(3'b100, 8'h0D, 8'h0B, lat);
        n_cmp++;
        if (res !== 16'h008F) begin n_bad++; $display("FAIL mul_0d_0b: got %h want 008f", res); end
        retire();
        run_cmd(3'b100, 8'h00, 8'h7F, lat);
        n_cmp++;
        if ({res, c, z, err} !== {16'h0000, 1'b0, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL mul_zero: got res=%h c=%b z=%b err=%b want res=0000 c=0 z=1 err=0", res, c, z, err);
        end
        retire();
    endtask

    task automatic test_backpressure();
        run_cmd(3'b000, 8'h01, 8'h01, lat);
        in_valid = 1'b1; op = 3'b000; a = 8'h10; b = 8'h10;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({out_valid, in_ready, res} !== {1'b1, 1'b0, 16'h0002}) begin
                n_bad++; $display("FAIL bp_hold[%0d]: got ov=%b ir=%b res=%h want ov=1 ir=0 res=0002", i, out_valid, in_ready, res);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        retire();
        n_cmp++;
        if ({out_valid, in_ready, res} !== {1'b0, 1'b1, 16'h0002}) begin
            n_bad++; $display("FAIL bp_retire: got ov=%b ir=%b res=%h want ov=0 ir=1 res=0002", out_valid, in_ready, res);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_bad++; $display("FAIL bp_not_queued: got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
        end
    endtask

    task automatic test_illegal();
        run_cmd(3'b111, 8'h12, 8'h34, lat);
        n_cmp++;
        if ({res, c, z, err} !== {16'h0000, 1'b0, 1'b1, 1'b1}) begin
            n_bad++; $display("FAIL illegal_111: got res=%h c=%b z=%b err=%b want res=0000 c=0 z=1 err=1", res, c, z, err);
        end
        retire();
        run_cmd(3'b101, 8'hFF, 8'h01, lat);
        n_cmp++;
        if ({res, c, z, err} !== {16'h0000, 1'b0, 1'b1, 1'b1}) begin
            n_bad++; $display("FAIL illegal_101: got res=%h c=%b z=%b err=%b want res=0000 c=0 z=1 err=1", res, c, z, err);
        end
        retire();
    endtask

    task automatic test_mul_reset();
        run_cmd(3'b011, 8'h77, 8'h00, lat);
        retire();
        in_valid = 1'b1; op = 3'b100; a = 8'hFF; b = 8'hFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, in_ready, res, c, z, err} !== {1'b0, 1'b1, 16'h0000, 3'b000}) begin
            n_bad++; $display("FAIL mul_abort: got ov=%b ir=%b res=%h c=%b z=%b err=%b want ov=0 ir=1 res=0000 c=0 z=0 err=0",
                              out_valid, in_ready, res, c, z, err);
        end
        #2 rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_bad++; $display("FAIL mul_abort_silent: got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
        end
        run_cmd(3'b000, 8'h02, 8'h03, lat);
        n_cmp++;
        if ({res, c, z, err, lat} !== {16'h0005, 3'b000, 32'd2}) begin
            n_bad++; $display("FAIL add_after_reset: got res=%h c=%b z=%b err=%b lat=%0d want res=0005 c=0 z=0 err=0 lat=2",
                              res, c, z, err, lat);
        end
        retire();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 3'b000; a = 8'h00; b = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_add();
        test_sub();
        test_inc_pass();
        test_mul();
        test_backpressure();
        test_illegal();
        test_mul_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
